// File: rtl/calc_ctrl_if.sv
// Key-pad and ALU bus for calc_ctrl: host/bench side is master, controller is slave.
interface calc_ctrl_if #(parameter int OPW = 4);
  logic               key_valid;
  logic [1:0]         key_type;
  logic [3:0]         key_val;
  logic [OPW-1:0]     alu_a;
  logic [OPW-1:0]     alu_b;
  logic [3:0]         alu_mode;
  logic [2*OPW-1:0]   alu_out;
  logic               alu_neg;
  logic [2*OPW-1:0]   result;
  logic               result_neg;
  logic               result_valid;
  logic               busy;
  logic               err;

  modport master (
    output key_valid, key_type, key_val, alu_out, alu_neg,
    input  alu_a, alu_b, alu_mode, result, result_neg, result_valid, busy, err
  );
  modport slave (
    input  key_valid, key_type, key_val, alu_out, alu_neg,
    output alu_a, alu_b, alu_mode, result, result_neg, result_valid, busy, err
  );
endinterface

// File: rtl/calc_ctrl.sv
// Calculator key-sequence controller driving an external combinational ALU.
// Define CALC_DIV_EN to build the DIV state with its restoring divider.
module calc_ctrl #(parameter int OPW = 4) (
  input  logic        clk,
  input  logic        rst_n,
  calc_ctrl_if.slave  bus
);
  localparam int W = 2*OPW;

`ifdef CALC_DIV_EN
  typedef enum logic [2:0] {IDLE, GOT_A, GOT_OP, GOT_B, EXEC, DIV, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, GOT_A, GOT_OP, GOT_B, EXEC, DONE} state_t;
`endif

  state_t         st;
  logic [OPW-1:0] a_q, b_q;
  logic [3:0]     mode_q;
  logic [W-1:0]   res_q;
  logic           neg_q, rv_q, busy_q, err_q;

  logic           is_dig, is_op, is_eq, is_clr, op_ok, op_rej;
  logic [OPW-1:0] dig;

  always_comb begin
    is_dig = bus.key_valid && (bus.key_type == 2'b00);
    is_op  = bus.key_valid && (bus.key_type == 2'b01);
    is_eq  = bus.key_valid && (bus.key_type == 2'b10);
    is_clr = bus.key_valid && (bus.key_type == 2'b11);
    dig    = OPW'(bus.key_val);
`ifdef CALC_DIV_EN
    op_ok  = (bus.key_val >= 4'd1) && (bus.key_val <= 4'd4);
    op_rej = 1'b0;
`else
    // divide is not built: code 4 is flagged rather than silently dropped
    op_ok  = (bus.key_val >= 4'd1) && (bus.key_val <= 4'd3);
    op_rej = (bus.key_val == 4'd4);
`endif
  end

`ifdef CALC_DIV_EN
  localparam int CW = $clog2(OPW) + 1;
  logic [OPW-1:0] dq_q, dr_q, dq_nx, dr_nx;
  logic [CW-1:0]  dcnt_q;
  logic [OPW:0]   dsh, dtr;

  // one restoring step: shift next dividend bit into the remainder, try subtract
  always_comb begin
    dsh   = {dr_q, dq_q[OPW-1]};
    dtr   = dsh - {1'b0, b_q};
    dr_nx = dtr[OPW] ? dsh[OPW-1:0] : dtr[OPW-1:0];
    dq_nx = {dq_q[OPW-2:0], ~dtr[OPW]};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE; a_q <= '0; b_q <= '0; mode_q <= '0; res_q <= '0;
      neg_q <= 1'b0; rv_q <= 1'b0; busy_q <= 1'b0; err_q <= 1'b0;
`ifdef CALC_DIV_EN
      dq_q <= '0; dr_q <= '0; dcnt_q <= '0;
`endif
    end else if (is_clr) begin
      st <= IDLE; a_q <= '0; b_q <= '0; mode_q <= '0; res_q <= '0;
      neg_q <= 1'b0; rv_q <= 1'b0; busy_q <= 1'b0; err_q <= 1'b0;
`ifdef CALC_DIV_EN
      dq_q <= '0; dr_q <= '0; dcnt_q <= '0;
`endif
    end else begin
      case (st)
        IDLE: if (is_dig) begin
          a_q <= dig; err_q <= 1'b0; st <= GOT_A;
        end
        GOT_A: begin
          if (is_dig) begin
            a_q <= dig; err_q <= 1'b0;
          end else if (is_op) begin
            if (op_ok) begin
              mode_q <= bus.key_val; st <= GOT_OP;
            end else if (op_rej) err_q <= 1'b1;
          end else if (is_eq) begin
            res_q <= {{OPW{1'b0}}, a_q}; neg_q <= 1'b0; rv_q <= 1'b1; st <= DONE;
          end
        end
        GOT_OP: begin
          if (is_dig) begin
            b_q <= dig; err_q <= 1'b0; st <= GOT_B;
          end else if (is_op) begin
            if (op_ok) mode_q <= bus.key_val;
            else if (op_rej) err_q <= 1'b1;
          end
        end
        GOT_B: begin
          if (is_dig) begin
            b_q <= dig; err_q <= 1'b0;
          end else if (is_eq) begin
            busy_q <= 1'b1;
`ifdef CALC_DIV_EN
            if (mode_q == 4'd4) begin
              st <= DIV; dq_q <= a_q; dr_q <= '0; dcnt_q <= '0;
            end else st <= EXEC;
`else
            st <= EXEC;
`endif
          end
        end
        EXEC: begin
          res_q <= bus.alu_out; neg_q <= bus.alu_neg;
          busy_q <= 1'b0; rv_q <= 1'b1; st <= DONE;
        end
`ifdef CALC_DIV_EN
        DIV: begin
          if (b_q == '0) begin
            err_q <= 1'b1; res_q <= '0; neg_q <= 1'b0;
            busy_q <= 1'b0; rv_q <= 1'b1; st <= DONE;
          end else begin
            dq_q <= dq_nx; dr_q <= dr_nx; dcnt_q <= dcnt_q + CW'(1);
            if (dcnt_q == CW'(OPW-1)) begin
              res_q <= {dr_nx, dq_nx}; neg_q <= 1'b0;
              busy_q <= 1'b0; rv_q <= 1'b1; st <= DONE;
            end
          end
        end
`endif
        DONE: begin
          if (is_dig) begin
            a_q <= dig; rv_q <= 1'b0; err_q <= 1'b0; res_q <= '0; neg_q <= 1'b0;
            st <= GOT_A;
          end else if (is_op) begin
            // chaining keeps only the low operand bits of the magnitude
            if (op_ok) begin
              a_q <= res_q[OPW-1:0]; mode_q <= bus.key_val; rv_q <= 1'b0;
              st <= GOT_OP;
            end else if (op_rej) err_q <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;
  assign bus.alu_mode     = mode_q;
  assign bus.result       = res_q;
  assign bus.result_neg   = neg_q;
  assign bus.result_valid = rv_q;
  assign bus.busy         = busy_q;
  assign bus.err          = err_q;
endmodule
